// File: rtl/floppy_pkg.sv
// Shared floppy subsystem definitions: arbiter state encoding, sector buffer
// geometry, buffer-port ids and the CPU mailbox request codes.
package floppy_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned SECTOR_SIZE = 1024;
    localparam int unsigned ADDR_W      = $clog2(SECTOR_SIZE);

    localparam logic PORT_FDC = 1'b0;
    localparam logic PORT_CPU = 1'b1;

    localparam logic [7:0] REQ_READ     = 8'h10;
    localparam logic [7:0] REQ_WRITE    = 8'h20;
    localparam logic [7:0] REQ_READADDR = 8'h30;
    localparam logic [7:0] REQ_NOP      = 8'h40;
    localparam logic [7:0] REQ_ACK      = 8'h80;
    localparam logic [7:0] REQ_FAIL     = 8'hC0;

endpackage

// File: rtl/floppy_bufarb_rr.sv
// Combinational 2-way round-robin picker for the sector buffer: on a tie the
// port not granted last wins; an active lock masks the FDC and forces the CPU.
module floppy_bufarb_rr (
    input  logic fdc_req,
    input  logic cpu_req,
    input  logic last,
    input  logic lock,
    output logic valid,
    output logic port,
    output logic forced
);
    import floppy_pkg::*;

    logic fdc_eff;

    always_comb begin
        fdc_eff = fdc_req & ~lock;
        valid   = fdc_eff | cpu_req;
        forced  = lock & cpu_req;
        port    = PORT_FDC;
        if (fdc_eff && cpu_req) begin
            port = (last == PORT_CPU) ? PORT_FDC : PORT_CPU;
        end else if (cpu_req) begin
            port = PORT_CPU;
        end
    end

endmodule

// File: rtl/floppy_bufarb.sv
// Sector buffer arbiter/sequencer: serialises FDC and CPU accesses to the
// single-port RAM. Optional CPU lock is enabled by FLOPPY_BUFARB_LOCK_EN.
module floppy_bufarb #(
    parameter int unsigned ADDR_W = floppy_pkg::ADDR_W,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic [ADDR_W-1:0] fdc_addr,
    input  logic              fdc_rd,
    input  logic              fdc_wr,
    input  logic [DATA_W-1:0] fdc_wdata,
    output logic [DATA_W-1:0] fdc_rdata,
    output logic              fdc_ack,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              cpu_lock,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       conflicts
);
    import floppy_pkg::*;

`ifdef FLOPPY_BUFARB_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic              last_q, port_q, wr_q, forced_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, fdc_rdata_q, cpu_rdata_q;
    logic [15:0]       conflicts_q;

    logic fdc_req, cpu_req, lock_eff, both_req;
    logic grant_valid, grant_port, grant_forced;
    logic live, in_done, rd_done;

    assign fdc_req  = fdc_rd | fdc_wr;
    assign cpu_req  = cpu_rd | cpu_wr;
    assign lock_eff = cpu_lock & LOCK_EN;
    assign both_req = fdc_req & ~lock_eff & cpu_req;

    floppy_bufarb_rr u_rr (
        .fdc_req (fdc_req),
        .cpu_req (cpu_req),
        .last    (last_q),
        .lock    (lock_eff),
        .valid   (grant_valid),
        .port    (grant_port),
        .forced  (grant_forced)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_valid) state_d = GRANT;
            GRANT:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= PORT_CPU;
            port_q      <= PORT_FDC;
            wr_q        <= 1'b0;
            forced_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            fdc_rdata_q <= '0;
            cpu_rdata_q <= '0;
            conflicts_q <= '0;
        end else if (clken) begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (both_req && conflicts_q != '1) begin
                        conflicts_q <= conflicts_q + 16'd1;
                    end
                    if (grant_valid) begin
                        port_q   <= grant_port;
                        forced_q <= grant_forced;
                        if (grant_port == PORT_CPU) begin
                            wr_q    <= cpu_wr;
                            addr_q  <= cpu_addr;
                            wdata_q <= cpu_wdata;
                        end else begin
                            wr_q    <= fdc_wr;
                            addr_q  <= fdc_addr;
                            wdata_q <= fdc_wdata;
                        end
                    end
                end
                DONE: begin
                    if (!wr_q) begin
                        if (port_q == PORT_CPU) cpu_rdata_q <= ram_rdata;
                        else                    fdc_rdata_q <= ram_rdata;
                    end
                    if (!forced_q) last_q <= port_q;
                end
                default: ;
            endcase
        end
    end

    // Gating with ~reset kills the strobe/ack of an access aborted by reset.
    assign live    = clken & ~reset;
    assign in_done = (state_q == DONE);
    assign rd_done = in_done & ~wr_q;

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = wr_q & live & (state_q == GRANT);
    assign fdc_ack   = live & in_done & (port_q == PORT_FDC);
    assign cpu_ack   = live & in_done & (port_q == PORT_CPU);
    assign conflicts = conflicts_q;

    // Read data is forwarded during DONE so it is valid alongside the ack.
    assign fdc_rdata = (rd_done && port_q == PORT_FDC) ? ram_rdata : fdc_rdata_q;
    assign cpu_rdata = (rd_done && port_q == PORT_CPU) ? ram_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_floppy_bufarb.sv
// Directed bench for floppy_bufarb with a behavioural 1 KiB synchronous RAM.
module tb_floppy_bufarb;

    logic       clk = 1'b0;
    logic       reset, clken;
    logic [9:0] fdc_addr, cpu_addr, ram_addr;
    logic       fdc_rd, fdc_wr, cpu_rd, cpu_wr, cpu_lock;
    logic [7:0] fdc_wdata, cpu_wdata, fdc_rdata, cpu_rdata, ram_wdata, ram_rdata;
    logic       fdc_ack, cpu_ack, ram_we;
    logic [15:0] conflicts;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [7:0] mem [0:1023];

    floppy_bufarb #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .clken(clken),
        .fdc_addr(fdc_addr), .fdc_rd(fdc_rd), .fdc_wr(fdc_wr),
        .fdc_wdata(fdc_wdata), .fdc_rdata(fdc_rdata), .fdc_ack(fdc_ack),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_lock(cpu_lock),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic [1:0]  fop;   // bit0 rd, bit1 wr
        logic [9:0]  fa;
        logic [7:0]  fd;
        logic [1:0]  cop;
        logic [9:0]  ca;
        logic [7:0]  cd;
        logic        eport; // 0 FDC, 1 CPU
        logic [7:0]  erd;
        int unsigned ewe;
        logic [15:0] econf;
        logic [9:0]  eaddr;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_ports();
        fdc_rd = 0; fdc_wr = 0; cpu_rd = 0; cpu_wr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; clken = 1; idle_ports();
        repeat (3) @(negedge clk);
        reset = 0;
    endtask

    initial begin
        vec_t v;
        int unsigned we_cnt, ack_cnt, ack_k, we_bad, fa_cnt, ca_cnt;
        logic got;
        logic [1:0] ack_seq [4];

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h005] = 8'hA5;
        mem[10'h100] = 8'hC3;
        mem[10'h200] = 8'h3C;

        reset = 1; clken = 1; cpu_lock = 0;
        fdc_addr = '0; cpu_addr = '0; fdc_wdata = '0; cpu_wdata = '0;
        idle_ports();

        //            fop  fa      fd     cop  ca      cd    port rd    we conf   addr
        vecs[0] = '{2'd1, 10'h005, 8'h00, 2'd0, 10'h000, 8'h00, 1'b0, 8'hA5, 0, 16'd0, 10'h005};
        vecs[1] = '{2'd0, 10'h000, 8'h00, 2'd2, 10'h3FF, 8'h5A, 1'b1, 8'h00, 1, 16'd0, 10'h3FF};
        vecs[2] = '{2'd1, 10'h3FF, 8'h00, 2'd0, 10'h000, 8'h00, 1'b0, 8'h5A, 0, 16'd0, 10'h3FF};
        vecs[3] = '{2'd1, 10'h005, 8'h00, 2'd1, 10'h3FF, 8'h00, 1'b1, 8'h5A, 0, 16'd1, 10'h3FF};
        vecs[4] = '{2'd2, 10'h000, 8'h11, 2'd1, 10'h005, 8'h00, 1'b0, 8'h00, 1, 16'd2, 10'h000};
        vecs[5] = '{2'd3, 10'h001, 8'h22, 2'd0, 10'h000, 8'h00, 1'b0, 8'h00, 1, 16'd2, 10'h001};
        vecs[6] = '{2'd0, 10'h000, 8'h00, 2'd1, 10'h000, 8'h00, 1'b1, 8'h11, 0, 16'd2, 10'h000};
        vecs[7] = '{2'd0, 10'h000, 8'h00, 2'd1, 10'h001, 8'h00, 1'b1, 8'h22, 0, 16'd2, 10'h001};
        vecs[8] = '{2'd1, 10'h001, 8'h00, 2'd2, 10'h002, 8'h33, 1'b0, 8'h22, 0, 16'd3, 10'h001};
        vecs[9] = '{2'd1, 10'h000, 8'h00, 2'd1, 10'h002, 8'h00, 1'b1, 8'h00, 0, 16'd4, 10'h002};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_acks", {fdc_ack, cpu_ack}, 0);
        chk("rst_rdata", {fdc_rdata, cpu_rdata}, 0);
        chk("rst_conflicts", conflicts, 0);
        reset = 0;

        // Table-driven single arbitration decisions
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            fdc_rd = v.fop[0]; fdc_wr = v.fop[1]; fdc_addr = v.fa; fdc_wdata = v.fd;
            cpu_rd = v.cop[0]; cpu_wr = v.cop[1]; cpu_addr = v.ca; cpu_wdata = v.cd;
            we_cnt = 0; got = 0;
            for (int c = 0; c < 6 && !got; c++) begin
                @(posedge clk); @(negedge clk);
                if (ram_we) we_cnt++;
                if (c == 0) chk($sformatf("v%0d_ram_addr", i), ram_addr, v.eaddr);
                if (fdc_ack || cpu_ack) begin
                    got = 1;
                    chk($sformatf("v%0d_ack_latency", i), c, 1);
                    chk($sformatf("v%0d_ack_port", i), {fdc_ack, cpu_ack}, v.eport ? 2'b01 : 2'b10);
                    if (v.ewe == 0)
                        chk($sformatf("v%0d_rdata", i), v.eport ? cpu_rdata : fdc_rdata, v.erd);
                    idle_ports();
                end
            end
            if (!got) begin
                chk($sformatf("v%0d_ack_timeout", i), 0, 1);
                idle_ports();
            end
            repeat (2) begin @(posedge clk); @(negedge clk); end
            chk($sformatf("v%0d_we_count", i), we_cnt, v.ewe);
            chk($sformatf("v%0d_conflicts", i), conflicts, v.econf);
            if (v.ewe == 0)
                chk($sformatf("v%0d_rdata_held", i), v.eport ? cpu_rdata : fdc_rdata, v.erd);
        end
        chk("v_mem_3ff", mem[10'h3FF], 8'h5A);
        chk("v_mem_002_untouched", mem[10'h002], 8'h00);

        // Full contention from reset: alternate FDC/CPU, 3 cycles apart
        do_reset();
        fdc_rd = 1; fdc_addr = 10'h100; cpu_rd = 1; cpu_addr = 10'h200;
        ack_cnt = 0; we_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); @(negedge clk);
            if (fdc_ack || cpu_ack) begin
                chk($sformatf("cont_ack_cycle%0d", ack_cnt), c, 1 + 3 * ack_cnt);
                if (ack_cnt < 4) ack_seq[ack_cnt] = {fdc_ack, cpu_ack};
                ack_cnt++;
            end
            if (ram_we) we_cnt++;
        end
        idle_ports();
        chk("cont_ack_count", ack_cnt, 4);
        if (ack_cnt >= 4) begin
            chk("cont_seq0", ack_seq[0], 2'b10);
            chk("cont_seq1", ack_seq[1], 2'b01);
            chk("cont_seq2", ack_seq[2], 2'b10);
            chk("cont_seq3", ack_seq[3], 2'b01);
        end
        chk("cont_conflicts", conflicts, 4);
        chk("cont_no_we", we_cnt, 0);
        chk("cont_rdata", {fdc_rdata, cpu_rdata}, 16'hC33C);

        // Reset asserted in GRANT of a CPU write
        @(negedge clk);
        cpu_wr = 1; cpu_addr = 10'h020; cpu_wdata = 8'h99;
        @(posedge clk); #1;
        reset = 1; idle_ports();
        @(negedge clk);
        chk("rstg_we_during_reset", ram_we, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("rstg_ram_addr", ram_addr, 0);
        chk("rstg_ram_wdata", ram_wdata, 0);
        chk("rstg_conflicts", conflicts, 0);
        chk("rstg_rdata", {fdc_rdata, cpu_rdata}, 0);
        we_cnt = 0; ack_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (ram_we) we_cnt++;
            if (cpu_ack || fdc_ack) ack_cnt++;
            @(posedge clk); @(negedge clk);
        end
        chk("rstg_no_we", we_cnt, 0);
        chk("rstg_no_ack", ack_cnt, 0);
        chk("rstg_mem", mem[10'h020], 8'h00);

        // clken high one clock in four during a CPU write
        do_reset();
        @(negedge clk);
        clken = 0;
        cpu_wr = 1; cpu_addr = 10'h010; cpu_wdata = 8'h77;
        we_cnt = 0; ack_cnt = 0; ack_k = 0; we_bad = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            clken = (k % 4 == 3);
            @(negedge clk);
            if (ram_we) begin
                we_cnt++;
                if (!clken) we_bad++;
            end
            if (cpu_ack) begin
                ack_cnt++;
                ack_k = k;
                idle_ports();
            end
        end
        clken = 1;
        chk("ce_we_count", we_cnt, 1);
        chk("ce_we_outside_clken", we_bad, 0);
        chk("ce_ack_count", ack_cnt, 1);
        chk("ce_ack_clock", ack_k, 11);
        chk("ce_mem", mem[10'h010], 8'h77);

`ifdef FLOPPY_BUFARB_LOCK_EN
        // CPU lock: FDC starved, no conflicts counted, FDC first after release
        do_reset();
        @(negedge clk);
        cpu_lock = 1;
        fdc_rd = 1; fdc_addr = 10'h100; cpu_rd = 1; cpu_addr = 10'h200;
        fa_cnt = 0; ca_cnt = 0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); @(negedge clk);
            if (fdc_ack) fa_cnt++;
            if (cpu_ack) ca_cnt++;
        end
        chk("lock_cpu_acks", ca_cnt, 3);
        chk("lock_fdc_acks", fa_cnt, 0);
        chk("lock_conflicts", conflicts, 0);
        cpu_lock = 0;
        got = 0;
        for (int c = 0; c < 3 && !got; c++) begin
            @(posedge clk); @(negedge clk);
            if (fdc_ack || cpu_ack) begin
                got = 1;
                chk("unlock_first_grant", {fdc_ack, cpu_ack}, 2'b10);
            end
        end
        if (!got) chk("unlock_ack_timeout", 0, 1);
        idle_ports();
        chk("unlock_conflicts", conflicts, 1);
`else
        fa_cnt = 0; ca_cnt = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/floppy_bufarb.md
# floppy_bufarb

Two-port arbiter and access sequencer for the single-port 1 KiB floppy sector buffer RAM. It shares the buffer between the FDC core (byte-stream side that emulated WD1793 software reads and writes) and the workhorse CPU (fills and drains sectors from the SD card). It serialises their accesses with round-robin fairness and lets the CPU lock the buffer for a whole sector transfer. It sits between both buffer-port masters and the RAM macro in the floppy subsystem.

## Interface
- `ADDR_W`, 10, buffer address width (1024-byte sector)
- `DATA_W`, 8, data width
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `clken` in 1: clock enable; all state advances only when high
- `fdc_addr` in ADDR_W: FDC address
- `fdc_rd` in 1: FDC read request (level)
- `fdc_wr` in 1: FDC write request (level)
- `fdc_wdata` in DATA_W: FDC write data
- `fdc_rdata` out DATA_W: FDC read data, held until next FDC read ack
- `fdc_ack` out 1: one-clken-cycle completion pulse
- `cpu_addr`, `cpu_rd`, `cpu_wr`, `cpu_wdata`, `cpu_rdata`, `cpu_ack`: CPU port; same meanings and widths as the FDC port
- `cpu_lock` in 1: CPU exclusive-ownership request
- `ram_addr` out ADDR_W: RAM address, registered
- `ram_we` out 1: RAM write strobe
- `ram_wdata` out DATA_W: RAM write data, registered
- `ram_rdata` in DATA_W: RAM read data, 1-cycle synchronous latency
- `conflicts` out 16: saturating count of cycles in which both ports requested

## Operation
- States: IDLE, GRANT, DONE.
- IDLE: pick a port among requesters, where req = rd|wr. Latch addr, wdata, and op (write wins if rd&wr are both high). Go to GRANT.
- Tie resolution: the port not granted last wins. `last` resets to CPU, so the FDC wins the first tie.
- GRANT: `ram_addr`/`ram_wdata` hold latched values. `ram_we` = latched-write & clken & (state==GRANT), so exactly one write strobe. Go to DONE.
- DONE: for a read, capture `ram_rdata` into that port's rdata. Pulse that port's ack. Update `last`. Go to IDLE.
- A request still asserted in the IDLE cycle after its ack starts a new access. Masters must drop the request when they see ack.
- Request deasserted while pending in GRANT/DONE: the access still completes and acks. It is not cancelled.
- `conflicts` increments in any clken cycle in IDLE with both reqs high. It saturates at 16'hFFFF.
- Lock: see Configuration. A lock never aborts an in-flight access.

## Timing
- Cycle counts are clken cycles. A request sampled in IDLE at cycle 0 gives: cycle 1 GRANT, RAM address presented, write strobe issued; cycle 2 DONE, rdata valid and ack high; cycle 3 IDLE.
- 3-cycle turnaround per access. Worst-case wait for one port under full contention: 6 cycles.
- With clken low, state, ack, and `ram_we` are all frozen or low. An ack spanning a clken-low gap is seen as one pulse on the next enabled edge.
- Reset values: state IDLE; `fdc_rdata` = `cpu_rdata` = 0; acks 0; `ram_addr` 0; `ram_wdata` 0; `ram_we` 0; `conflicts` 0; `last` = CPU.
- Reset asserted in GRANT suppresses the write. There is no ack for the aborted access.

## Configuration
- Macro `FLOPPY_BUFARB_LOCK_EN`.
- Defined:
  - While `cpu_lock`=1 in IDLE, FDC requests are ignored and do not count as conflicts.
  - CPU requests are served back-to-back.
  - `last` is not updated by lock-forced grants.
- Undefined: `cpu_lock` is ignored; the port remains, unused.

## Structure
- Shared `floppy_pkg` holds:
  - state enum (IDLE/GRANT/DONE)
  - `SECTOR_SIZE`=1024 and `ADDR_W`
  - port-id constants (PORT_FDC=0, PORT_CPU=1)
  - existing CPU request codes (READ 8'h10, WRITE 8'h20, READADDR 8'h30, NOP 8'h40, ACK 8'h80, FAIL 8'hC0)
- One sub-module: `floppy_bufarb_rr`, a 2-way round-robin picker (reqs, last, lock → grant valid + port id). It is combinational, and separately unit-testable.

## Test plan
- FDC read alone, addr 10'h005, RAM holding 8'hA5 → `ram_addr`=5 at cycle 1, `fdc_ack` at cycle 2, `fdc_rdata`=8'hA5 held afterward, `ram_we` never high.
- CPU write addr 10'h3FF data 8'h5A, then FDC read 10'h3FF → exactly one `ram_we` pulse, FDC reads 8'h5A, no address wrap.
- Both ports request continuously from reset → grants FDC, CPU, FDC, CPU…; each ack 3 cycles apart; `conflicts` increments once per IDLE visit.
- With `FLOPPY_BUFARB_LOCK_EN`, `cpu_lock`=1 and both requesting → only CPU acks, FDC acks 0, `conflicts` unchanged. After lock drops, FDC is granted next.
- clken toggling 1-in-4 during a write → exactly one `ram_we` pulse, coincident with clken. Timing scales to 12 clocks.
- Reset pulsed in GRANT of a CPU write → no `ram_we`, no `cpu_ack`, all outputs at reset values the next cycle.
